// File: rtl/and16_response_checker.sv
// and16_response_checker: checks gate responses against a golden bitwise op, counting vectors and errors
module and16_response_checker #(
  parameter int WIDTH = 16,
  parameter int OP = 0,
  parameter int unsigned NUM_VECTORS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      vec_count,
  output logic [15:0]      err_count,
  output logic [31:0]      fail_idx,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_y,
  output logic             fail_valid
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [31:0] LAST = 32'(NUM_VECTORS - 1);
  state_t r_state, w_next;
  logic w_accept, w_start, w_mis;
  logic r_v1, r_v2, r_fv;
  logic [WIDTH-1:0] r_a1, r_b1, r_y1, r_a2, r_b2, r_y2, r_g2, r_fa, r_fb, r_fy;
  logic [31:0] r_acc, r_vec, r_fidx;
  logic [15:0] r_err;
  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return OP == 0 ? a & b : OP == 1 ? ~(a & b) : OP == 2 ? a | b : a ^ b;
  endfunction
  assign in_ready = r_state == RUN;
  assign busy = r_state == RUN || r_state == DRAIN;
  assign done = r_state == DONE;
  assign pass = done && r_err == 16'd0;
  assign w_accept = in_valid && in_ready;
  assign w_start = start && (r_state == IDLE || r_state == DONE);
  assign w_mis = r_y2 != r_g2;
  assign vec_count = r_vec;
  assign err_count = r_err;
  assign fail_idx = r_fidx;
  assign fail_a = r_fa;
  assign fail_b = r_fb;
  assign fail_y = r_fy;
  assign fail_valid = r_fv;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = w_start ? RUN
           : r_state == RUN ? (w_accept && r_acc == LAST ? DRAIN : RUN)
           : r_state == DRAIN ? (!r_v1 && !r_v2 ? DONE : DRAIN)
           : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_acc <= '0;
      r_vec <= '0;
      r_err <= '0;
      r_fidx <= '0;
      r_fa <= '0;
      r_fb <= '0;
      r_fy <= '0;
      r_fv <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_acc <= r_acc + 32'(w_accept);
      if (w_accept) {r_a1, r_b1, r_y1} <= {in_a, in_b, in_y};
      if (r_v1) {r_a2, r_b2, r_y2, r_g2} <= {r_a1, r_b1, r_y1, golden(r_a1, r_b1)};
      if (r_v2) begin
        r_vec <= r_vec + 32'd1;
        if (w_mis && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (w_mis && !r_fv) begin
          r_fv <= 1'b1;
          r_fidx <= r_vec;
          {r_fa, r_fb, r_fy} <= {r_a2, r_b2, r_y2};
        end
      end
    end
  end
endmodule
